sdf_butterfly_stage: RTL and testbench
======================================

Name: sdf_butterfly_stage

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage of the 64-point FFT pipeline.
- Sits directly downstream of the twiddle complex multiplier and consumes its 32-bit {real16, imag16} product stream.
- Pairs samples DELAY apart and emits scaled sum/difference results, in stream order, to the next stage.

Parameters:
- DELAY, 32, butterfly span in samples: 32, 16, …, 1 across the six stages. Power of two, ≥1.
- CW, 6, index counter width. Must equal log2(2*DELAY)+… ; set so that 2^CW ≥ 2*DELAY.

Ports:
- CLK, input, 1, single clock; all logic rising-edge.
- RST_N, input, 1, reset, asynchronous and active-low.
- DIN32, input, 32, input sample: [31:16] real, [15:0] imag, two's complement Q1.15.
- DIN_VALID, input, 1, DIN32 valid this cycle. Stream has no backpressure.
- DIN_SYNC, input, 1, qualified by DIN_VALID; marks sample index 0 of a frame.
- DOUT32, output, 32, result sample, same packing.
- DOUT_VALID, output, 1, DOUT32 valid.
- DOUT_SYNC, output, 1, marks first result of a frame (sum for index 0).
- FRAME_ERR, output, 1, one-cycle pulse when DIN_SYNC arrives with index ≠ 0.

Behaviour:
- Reset state: DOUT32=0, DOUT_VALID=0, DOUT_SYNC=0, FRAME_ERR=0, IDX=0, PRIMED=0. Delay-line contents are not reset and are don't-care.
- Everything advances only on accepted samples (DIN_VALID=1). With DIN_VALID=0: delay line, IDX and PRIMED hold, and DOUT_VALID=0 next cycle.
- IDX (CW bits) counts accepted samples modulo 2*DELAY. PHASE = IDX≥DELAY.
- Delay line: DELAY-entry FIFO of 32-bit words. HEAD is the oldest entry. Each accepted sample does one push and one pop.
- PHASE 0 (IDX<DELAY), fill:
  - Push DIN32.
  - Output HEAD, which is a difference stored in the previous frame.
  - DOUT_VALID=PRIMED.
- PHASE 1 (IDX≥DELAY), butterfly, componentwise on real and imag:
  - S = HEAD + DIN, computed 17-bit, then scaled to 16-bit.
  - D = HEAD − DIN, same rule.
  - Output S with DOUT_VALID=1. Push D.
- Scaling: arithmetic right shift by 1 of the 17-bit result (floor). This never overflows: range −32768..32767.
- PRIMED: set when the last PHASE 1 sample (IDX=2*DELAY−1) is accepted. Cleared on reset or on FRAME_ERR.
- Latency: DOUT is registered and appears exactly 1 cycle after the accepted DIN that produced it.
- Output order per frame: DELAY sums (indices 0..DELAY−1), then on the next frame's PHASE 0 the DELAY matching differences.
- Flushing: upstream drives DELAY further samples (zeros acceptable) to drain the final differences.
- DOUT_SYNC=1 with the sum for IDX=DELAY.
- DIN_SYNC rules:
  - When IDX=0: normal, no effect.
  - When IDX≠0: FRAME_ERR pulses, IDX is forced so this sample becomes index 0, PRIMED clears, and outputs for this sample are suppressed (DOUT_VALID=0).
- DELAY=1: the FIFO degenerates to one register; the rules are unchanged.
- Reset mid-frame: everything returns to the reset state immediately; the first post-reset sample is index 0.

Optional Feature:
- Macro: FFT_BF_ROUND_EN.
- Defined: S and D use round-half-up, (x+1)>>>1 on the 17-bit value. The maximum positive sum 65534 gives 32767, so no saturation is needed.
- Undefined: truncation (floor), as above.
- Latency and control behaviour are identical in both builds.

Decomposition:
- Shared include fft_defs.vh holds:
  - Sample width constant (16).
  - Pack/unpack macros or functions for {real, imag}.
  - Scale function (add → 17-bit → shift, with the FFT_BF_ROUND_EN variant). The twiddle multiplier and later stages use the same scale function.
- One natural sub-module, sdf_delay_line (parameter DEPTH):
  - Circular buffer with a single pointer: read-before-write at the same address.
  - Enable = DIN_VALID.
  - Exposes HEAD.
- The butterfly arithmetic, IDX counter and PRIMED/SYNC logic stay in sdf_butterfly_stage.

Test Plan:
1. DELAY=2, reset, continuous DIN_VALID. Real parts 4,8,2,6 then 0,0 (imag 0), DIN_SYNC on the first.
   - Outputs: sums 3,7 with DOUT_SYNC on 3, then differences 1,1.
   - No DOUT_VALID during the first two cycles.
2. DIN_VALID gaps: insert idle cycles between every accepted sample in scenario 1.
   - Identical DOUT sequence.
   - DOUT_VALID only 1 cycle after each accepted sample.
3. Overflow: HEAD=0x7FFF_8000, DIN=0x7FFF_8000.
   - Sum gives real 0x7FFF, imag 0x8000.
   - Difference gives 0x0000_0000.
4. Rounding: HEAD real=3, DIN real=0.
   - Sum is 1 without FFT_BF_ROUND_EN.
   - Sum is 2 with it.
5. DIN_SYNC asserted at IDX=3 (DELAY=2 stream).
   - FRAME_ERR pulses one cycle, DOUT_VALID=0 for that sample.
   - Next frame proceeds from index 0 with no difference outputs until PRIMED.
6. RST_N pulled low mid-PHASE 1.
   - All outputs 0 asynchronously.
   - After release, scenario 1 reproduces exactly.

Source files
------------

// File: rtl/sdf_butterfly_stage_pkg.sv
// Shared sample types and butterfly arithmetic for the FFT pipeline.
// Define FFT_BF_ROUND_EN for round-half-up scaling instead of floor.
package sdf_butterfly_stage_pkg;

    localparam int SW = 16;

    typedef logic signed [SW-1:0] sample_t;

    typedef struct packed {
        sample_t re;
        sample_t im;
    } cplx_t;

    function automatic cplx_t cx_unpack(
        input logic [2*SW-1:0] w
    );
        return cplx_t'(w);
    endfunction

    function automatic logic [2*SW-1:0] cx_pack(
        input cplx_t c
    );
        return c;
    endfunction

    // Halving the 17-bit result keeps every sum in the 16-bit range.
    function automatic sample_t bf_scale(
        input logic signed [SW:0] x
    );
`ifdef FFT_BF_ROUND_EN
        logic signed [SW:0] one;
        one = 1;
        return sample_t'((x + one) >>> 1);
`else
        return sample_t'(x >>> 1);
`endif
    endfunction

    function automatic sample_t bf_add(
        input sample_t a,
        input sample_t b
    );
        logic signed [SW:0] x;
        x = {a[SW-1], a} + {b[SW-1], b};
        return bf_scale(x);
    endfunction

    function automatic sample_t bf_sub(
        input sample_t a,
        input sample_t b
    );
        logic signed [SW:0] x;
        x = {a[SW-1], a} - {b[SW-1], b};
        return bf_scale(x);
    endfunction

    function automatic cplx_t cx_add(
        input cplx_t a,
        input cplx_t b
    );
        cplx_t r;
        r.re = bf_add(a.re, b.re);
        r.im = bf_add(a.im, b.im);
        return r;
    endfunction

    function automatic cplx_t cx_sub(
        input cplx_t a,
        input cplx_t b
    );
        cplx_t r;
        r.re = bf_sub(a.re, b.re);
        r.im = bf_sub(a.im, b.im);
        return r;
    endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// DEPTH-entry feedback FIFO as a circular buffer with one pointer.
// Each enabled cycle reads the oldest word and overwrites it in place.
module sdf_delay_line
    import sdf_butterfly_stage_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int W     = 2 * SW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] push,
    output logic [W-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;

    assign head = mem[ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            if (ptr == PTR_LAST) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PW'(1);
            end
        end
    end

    // Storage carries no reset; stale words are never emitted unprimed.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= push;
        end
    end

endmodule

// File: rtl/sdf_butterfly_stage.sv
// Radix-2 SDF butterfly stage: pairs samples DELAY apart in the stream.
// Build with FFT_BF_ROUND_EN for round-half-up sum/difference scaling.
module sdf_butterfly_stage
    import sdf_butterfly_stage_pkg::*;
#(
    parameter int DELAY = 32,
    parameter int CW    = 6
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] DIN32,
    input  logic        DIN_VALID,
    input  logic        DIN_SYNC,
    output logic [31:0] DOUT32,
    output logic        DOUT_VALID,
    output logic        DOUT_SYNC,
    output logic        FRAME_ERR
);

    localparam logic [CW-1:0] IDX_LAST = CW'(2 * DELAY - 1);
    localparam logic [CW-1:0] IDX_HALF = CW'(DELAY);

    logic [CW-1:0] idx;
    logic [CW-1:0] idx_eff;
    logic [CW-1:0] idx_nxt;
    logic          primed;
    logic          primed_nxt;
    logic          err;
    logic          phase;
    logic          last;
    logic [31:0]   head;
    logic [31:0]   push;
    logic [31:0]   res;
    cplx_t         h_c;
    cplx_t         x_c;
    cplx_t         s_c;
    cplx_t         d_c;

    sdf_delay_line #(
        .DEPTH (DELAY),
        .W     (2 * SW)
    ) u_dly (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (DIN_VALID),
        .push  (push),
        .head  (head)
    );

    // A misplaced sync restarts the frame on this very sample.
    always_comb begin
        err     = DIN_VALID && DIN_SYNC && (idx != '0);
        idx_eff = err ? '0 : idx;
        phase   = (idx_eff >= IDX_HALF);
        last    = (idx_eff == IDX_LAST);
        idx_nxt = last ? '0 : idx_eff + CW'(1);

        h_c = cx_unpack(head);
        x_c = cx_unpack(DIN32);
        s_c = cx_add(h_c, x_c);
        d_c = cx_sub(h_c, x_c);

        push = phase ? cx_pack(d_c) : DIN32;
        res  = phase ? cx_pack(s_c) : head;

        primed_nxt = primed;
        if (err) begin
            primed_nxt = 1'b0;
        end else if (last) begin
            primed_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx        <= '0;
            primed     <= 1'b0;
            DOUT32     <= '0;
            DOUT_VALID <= 1'b0;
            DOUT_SYNC  <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            FRAME_ERR  <= err;
            DOUT_VALID <= DIN_VALID && !err && (phase || primed);
            DOUT_SYNC  <= DIN_VALID && !err && (idx_eff == IDX_HALF);
            if (DIN_VALID) begin
                idx    <= idx_nxt;
                primed <= primed_nxt;
                DOUT32 <= res;
            end
        end
    end

endmodule

// File: tb/tb_sdf_butterfly_stage.sv
// Directed bench for sdf_butterfly_stage with DELAY=2.
// Expected values follow FFT_BF_ROUND_EN when it is defined.
module tb_sdf_butterfly_stage;

    typedef struct {
        logic        v;
        logic        s;
        logic [31:0] din;
        logic        ev;
        logic        es;
        logic        ee;
        logic [31:0] dout;
    } vec_t;

`ifdef FFT_BF_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] DIN32 = '0;
    logic        DIN_VALID = 1'b0;
    logic        DIN_SYNC = 1'b0;
    logic [31:0] DOUT32;
    logic        DOUT_VALID;
    logic        DOUT_SYNC;
    logic        FRAME_ERR;

    int total = 0;
    int bad = 0;

    vec_t t1[$];
    vec_t tab[$];

    sdf_butterfly_stage #(
        .DELAY (2),
        .CW    (3)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .DIN32      (DIN32),
        .DIN_VALID  (DIN_VALID),
        .DIN_SYNC   (DIN_SYNC),
        .DOUT32     (DOUT32),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_SYNC  (DOUT_SYNC),
        .FRAME_ERR  (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] cx(input int re, input int im);
        logic [31:0] w;
        w = {re[15:0], im[15:0]};
        return w;
    endfunction

    function automatic vec_t mk(
        input logic v, input logic s, input logic [31:0] din,
        input logic ev, input logic es, input logic ee,
        input logic [31:0] dout
    );
        vec_t t;
        t.v = v; t.s = s; t.din = din;
        t.ev = ev; t.es = es; t.ee = ee; t.dout = dout;
        return t;
    endfunction

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, k, act, exp);
        end
    endtask

    task automatic idle_outs(input string nm, input int k);
        chk({nm, ".valid"}, k, 32'(DOUT_VALID), 32'd0);
        chk({nm, ".sync"}, k, 32'(DOUT_SYNC), 32'd0);
        chk({nm, ".err"}, k, 32'(FRAME_ERR), 32'd0);
    endtask

    task automatic do_reset();
        DIN_VALID = 1'b0;
        DIN_SYNC  = 1'b0;
        DIN32     = '0;
        RST_N     = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        idle_outs("reset", 0);
        chk("reset.dout", 0, DOUT32, 32'd0);
        RST_N = 1'b1;
    endtask

    task automatic run_tab(input string nm, input bit gap);
        for (int k = 0; k < tab.size(); k++) begin
            DIN_VALID = tab[k].v;
            DIN_SYNC  = tab[k].s;
            DIN32     = tab[k].din;
            @(posedge CLK);
            #1;
            chk({nm, ".valid"}, k, 32'(DOUT_VALID), 32'(tab[k].ev));
            chk({nm, ".sync"}, k, 32'(DOUT_SYNC), 32'(tab[k].es));
            chk({nm, ".err"}, k, 32'(FRAME_ERR), 32'(tab[k].ee));
            if (tab[k].ev) begin
                chk({nm, ".dout"}, k, DOUT32, tab[k].dout);
            end
            if (gap) begin
                DIN_VALID = 1'b0;
                DIN_SYNC  = 1'b1;
                DIN32     = 32'hDEAD_BEEF;
                @(posedge CLK);
                #1;
                idle_outs({nm, ".gap"}, k);
            end
        end
        DIN_VALID = 1'b0;
        DIN_SYNC  = 1'b0;
    endtask

    initial begin
        // 4,8,2,6 -> sums 3,7 then differences 1,1, then zero frame
        t1.push_back(mk(1, 1, cx(4, 0), 0, 0, 0, 0));
        t1.push_back(mk(1, 0, cx(8, 0), 0, 0, 0, 0));
        t1.push_back(mk(1, 0, cx(2, 0), 1, 1, 0, cx(3, 0)));
        t1.push_back(mk(1, 0, cx(6, 0), 1, 0, 0, cx(7, 0)));
        t1.push_back(mk(1, 0, cx(0, 0), 1, 0, 0, cx(1, 0)));
        t1.push_back(mk(1, 0, cx(0, 0), 1, 0, 0, cx(1, 0)));
        t1.push_back(mk(1, 0, cx(0, 0), 1, 1, 0, cx(0, 0)));
        t1.push_back(mk(1, 0, cx(0, 0), 1, 0, 0, cx(0, 0)));

        do_reset();
        tab = t1;
        run_tab("basic", 1'b0);

        do_reset();
        tab = t1;
        run_tab("gaps", 1'b1);

        do_reset();
        tab.delete();
        tab.push_back(mk(1, 1, 32'h7FFF_8000, 0, 0, 0, 0));
        tab.push_back(mk(1, 0, cx(100, -100), 0, 0, 0, 0));
        tab.push_back(mk(1, 0, 32'h7FFF_8000, 1, 1, 0, 32'h7FFF_8000));
        tab.push_back(mk(1, 0, cx(-100, 100), 1, 0, 0, 32'h0000_0000));
        tab.push_back(mk(1, 0, cx(0, 0), 1, 0, 0, 32'h0000_0000));
        tab.push_back(mk(1, 0, cx(0, 0), 1, 0, 0, cx(100, -100)));
        run_tab("ovf", 1'b0);

        do_reset();
        tab.delete();
        tab.push_back(mk(1, 1, cx(3, 0), 0, 0, 0, 0));
        tab.push_back(mk(1, 0, cx(0, -3), 0, 0, 0, 0));
        tab.push_back(mk(1, 0, cx(0, 0), 1, 1, 0, cx(RND ? 2 : 1, 0)));
        tab.push_back(mk(1, 0, cx(0, 0), 1, 0, 0, cx(0, RND ? -1 : -2)));
        tab.push_back(mk(1, 0, cx(0, 0), 1, 0, 0, cx(RND ? 2 : 1, 0)));
        tab.push_back(mk(1, 0, cx(0, 0), 1, 0, 0, cx(0, RND ? -1 : -2)));
        run_tab("round", 1'b0);

        // Sync at index 3 restarts the frame; 6 becomes the new index 0
        do_reset();
        tab.delete();
        tab.push_back(mk(1, 1, cx(4, 0), 0, 0, 0, 0));
        tab.push_back(mk(1, 0, cx(8, 0), 0, 0, 0, 0));
        tab.push_back(mk(1, 0, cx(2, 0), 1, 1, 0, cx(3, 0)));
        tab.push_back(mk(1, 1, cx(6, 0), 0, 0, 1, 0));
        tab.push_back(mk(1, 0, cx(10, 0), 0, 0, 0, 0));
        tab.push_back(mk(1, 0, cx(2, 0), 1, 1, 0, cx(4, 0)));
        tab.push_back(mk(1, 0, cx(4, 0), 1, 0, 0, cx(7, 0)));
        tab.push_back(mk(1, 1, cx(0, 0), 1, 0, 0, cx(2, 0)));
        tab.push_back(mk(1, 0, cx(0, 0), 1, 0, 0, cx(3, 0)));
        run_tab("resync", 1'b0);

        // Asynchronous reset while a valid sum is on the output
        do_reset();
        tab.delete();
        for (int k = 0; k < 3; k++) begin
            tab.push_back(t1[k]);
        end
        run_tab("prerst", 1'b0);
        DIN_VALID = 1'b1;
        DIN32     = cx(6, 0);
        #2;
        RST_N = 1'b0;
        #1;
        idle_outs("asyncrst", 0);
        chk("asyncrst.dout", 0, DOUT32, 32'd0);
        DIN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        tab = t1;
        run_tab("postrst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
